fm7_sub_halt_ctrl: RTL and testbench
====================================

# fm7_sub_halt_ctrl

Main-to-sub CPU control block for the FM-7 core. It drives the sub CPU's halt request and the cancel (attention) IRQ, and tracks the sub CPU busy flag. It synchronises the sub CPU halt acknowledge and grants main CPU ownership of the shared RAM window only while the sub CPU is confirmed halted. It sits between the main CPU's $FD05 register decode and the sub CPU wrapper (SHALTn, SUBIRQn, SHALTSTn).

## Interface
Parameters:
- TIMEOUT_CYC, 255: cycles spent in HREQ before the sticky timeout flag is set; range 1..255, 8-bit counter.

Ports:
- SCPUCLK  in  1  single clock for all logic.
- RESET  in  1  synchronous, active-high reset.
- MWR_FD05  in  1  one-cycle strobe: main CPU write to $FD05.
- MDIN  in  8  main CPU write data. Bit7: 1 = halt sub, 0 = release. Bit6: 1 = raise cancel IRQ.
- MDOUT  out  8  status: {busy, cancel_pend, timeout, 4'b1111, halted}.
- SHALTSTn  in  1  sub CPU halt acknowledge (BA&BS inverted), asynchronous to internal state, possibly glitchy.
- SBUSY_SET  in  1  one-cycle strobe: sub CPU sets busy.
- SBUSY_CLR  in  1  one-cycle strobe: sub CPU clears busy.
- SATTN_ACK  in  1  one-cycle strobe: sub CPU reads the cancel register, which clears the IRQ.
- SHALTn  out  1  halt request to the sub CPU, active low, registered.
- SUBIRQn  out  1  cancel IRQ to the sub CPU, active low, registered.
- MSHGNT  out  1  main CPU owns the shared RAM, registered.

## Operation
- SHALTSTn passes through a 2-FF synchroniser (s1, s2). Only s2 is used.
- State machine: RUN, HREQ, HALTED, HREL.
  - RUN: SHALTn=1, MSHGNT=0. A write with bit7=1 goes to HREQ.
  - HREQ: SHALTn=0. When s2=0, go to HALTED. A write with bit7=0 goes to HREL.
  - HALTED: SHALTn=0, MSHGNT=1. A write with bit7=0 goes to HREL, and MSHGNT drops on the same edge.
  - HREL: SHALTn=1, MSHGNT=0. When s2=1, go to RUN. A write with bit7=1 goes to HREQ.
- Writes that do not change the requested halt state (bit7=1 in HREQ or HALTED, bit7=0 in RUN) are no-ops for the FSM.
- Timeout:
  - The 8-bit counter clears when HREQ is entered and increments each cycle in HREQ, saturating.
  - When the counter equals TIMEOUT_CYC, the sticky timeout flag sets.
  - The flag is cleared by any MWR_FD05, and also by the FSM reaching HALTED.
  - The FSM keeps waiting in HREQ; a timeout never forces a state change.
- Cancel IRQ:
  - A write with bit6=1 sets cancel_pend. SATTN_ACK clears it.
  - If both occur on the same edge, set wins.
  - SUBIRQn = ~cancel_pend, registered.
- Busy flag:
  - SBUSY_SET sets it; SBUSY_CLR clears it. If both occur on the same edge, set wins.
- MDOUT:
  - bit0 (halted) = state==HALTED.
  - MDOUT is combinational from registers.
- Reset values:
  - state=RUN, SHALTn=1, SUBIRQn=1, MSHGNT=0.
  - busy=1, because the sub CPU boots busy.
  - cancel_pend=0, timeout=0, counter=0, s1=s2=1.
  - MDOUT=8'h9E.
- Reset at any point, including mid-HREQ or HALTED, returns all of the above on the next edge. No handshake completion is required.

## Timing
- MWR_FD05 sampled at edge N:
  - SHALTn and SUBIRQn change after edge N (visible in cycle N+1).
  - MSHGNT falls after edge N on a release.
- SHALTSTn low sampled at edge A: s2=0 after A+1, state=HALTED after A+2. MSHGNT=1 from cycle A+3, i.e. 3-edge acknowledge latency.
- SHALTSTn high sampled at edge A while in HREL: state=RUN after A+2.
- A SHALTSTn pulse shorter than one cycle may be missed. The FSM must never grant on a pulse that does not reach s2.
- Simultaneous events:
  - MWR_FD05 with bit7=0 on the same edge that s2 falls in HREQ: the write wins, go to HREL, no grant pulse.
- Timeout flag sets on the edge where the counter transitions to TIMEOUT_CYC, i.e. TIMEOUT_CYC cycles after entering HREQ.

## Test plan
- Reset, then idle: MDOUT=8'h9E, SHALTn=1, SUBIRQn=1, MSHGNT=0.
- Write 8'h80, then drive SHALTSTn low 5 cycles later:
  - SHALTn=0 one cycle after the write.
  - MSHGNT=1 three edges after SHALTSTn falls; MDOUT bit0=1.
- From HALTED, write 8'h00:
  - MSHGNT=0 and SHALTn=1 immediately after the write edge.
  - With SHALTSTn raised, state reaches RUN two edges later.
- Write 8'h80 and hold SHALTSTn high with TIMEOUT_CYC=16:
  - MDOUT bit5=1 after 16 cycles, SHALTn stays 0.
  - A subsequent SHALTSTn low still produces the grant and clears bit5.
- Write 8'h40, then pulse SATTN_ACK and a second 8'h40 write on the same edge:
  - SUBIRQn=0 persists.
  - A later lone SATTN_ACK gives SUBIRQn=1.
- Assert RESET while HALTED with cancel_pend=1 and busy=0:
  - Next cycle: SHALTn=1, MSHGNT=0, SUBIRQn=1, MDOUT=8'h9E.

Source files
------------

// File: rtl/fm7_sub_halt_ctrl.sv
// Main-to-sub CPU halt/cancel control for the FM-7: halt request FSM with a
// synchronised halt acknowledge, shared-RAM grant, cancel IRQ and busy flag.
module fm7_sub_halt_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic       SCPUCLK,
    input  logic       RESET,
    input  logic       MWR_FD05,
    input  logic [7:0] MDIN,
    output logic [7:0] MDOUT,
    input  logic       SHALTSTn,
    input  logic       SBUSY_SET,
    input  logic       SBUSY_CLR,
    input  logic       SATTN_ACK,
    output logic       SHALTn,
    output logic       SUBIRQn,
    output logic       MSHGNT
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HREQ   = 2'd1,
        ST_HALTED = 2'd2,
        ST_HREL   = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_8 = 8'(TIMEOUT_CYC);

    state_t     state_q, state_d;
    logic       s1_q, s2_q;
    logic [7:0] cnt_q, cnt_d;
    logic       timeout_q, timeout_d;
    logic       cancel_q, cancel_d;
    logic       busy_q, busy_d;
    logic       shaltn_q, shaltn_d;
    logic       subirqn_q, subirqn_d;
    logic       gnt_q, gnt_d;
    logic       wr_halt, wr_rel, to_hit;
    logic       unused_mdin;

    assign wr_halt     = MWR_FD05 & MDIN[7];
    assign wr_rel      = MWR_FD05 & ~MDIN[7];
    assign unused_mdin = ^MDIN[5:0];

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:    if (wr_halt) state_d = ST_HREQ;
            // A release write beats an acknowledge arriving on the same edge.
            ST_HREQ:   if (wr_rel) state_d = ST_HREL;
                       else if (!s2_q) state_d = ST_HALTED;
            ST_HALTED: if (wr_rel) state_d = ST_HREL;
            ST_HREL:   if (wr_halt) state_d = ST_HREQ;
                       else if (s2_q) state_d = ST_RUN;
            default:   state_d = ST_RUN;
        endcase

        cnt_d = cnt_q;
        if (state_d == ST_HREQ && state_q != ST_HREQ)
            cnt_d = 8'd0;
        else if (state_q == ST_HREQ && cnt_q != 8'hFF)
            cnt_d = cnt_q + 8'd1;

        to_hit = (state_q == ST_HREQ) && (cnt_q != 8'hFF) && ((cnt_q + 8'd1) == TIMEOUT_8);
        timeout_d = timeout_q;
        if (MWR_FD05 || state_d == ST_HALTED)
            timeout_d = 1'b0;
        else if (to_hit)
            timeout_d = 1'b1;

        cancel_d = cancel_q;
        if (MWR_FD05 && MDIN[6])
            cancel_d = 1'b1;
        else if (SATTN_ACK)
            cancel_d = 1'b0;

        busy_d = busy_q;
        if (SBUSY_SET)
            busy_d = 1'b1;
        else if (SBUSY_CLR)
            busy_d = 1'b0;

        // Outputs are registered from the next state so they track it edge-for-edge.
        shaltn_d  = (state_d == ST_RUN) || (state_d == ST_HREL);
        gnt_d     = (state_d == ST_HALTED);
        subirqn_d = ~cancel_d;
    end

    always_ff @(posedge SCPUCLK) begin
        if (RESET) begin
            state_q   <= ST_RUN;
            s1_q      <= 1'b1;
            s2_q      <= 1'b1;
            cnt_q     <= 8'd0;
            timeout_q <= 1'b0;
            cancel_q  <= 1'b0;
            busy_q    <= 1'b1;
            shaltn_q  <= 1'b1;
            subirqn_q <= 1'b1;
            gnt_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            s1_q      <= SHALTSTn;
            s2_q      <= s1_q;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            cancel_q  <= cancel_d;
            busy_q    <= busy_d;
            shaltn_q  <= shaltn_d;
            subirqn_q <= subirqn_d;
            gnt_q     <= gnt_d;
        end
    end

    assign SHALTn  = shaltn_q;
    assign SUBIRQn = subirqn_q;
    assign MSHGNT  = gnt_q;
    assign MDOUT   = {busy_q, cancel_q, timeout_q, 4'b1111, (state_q == ST_HALTED)};

endmodule

// File: tb/tb_fm7_sub_halt_ctrl.sv
// Bench for fm7_sub_halt_ctrl: directed scenarios plus random traffic, all
// checked every cycle against a request/settled behavioural model.
module tb_fm7_sub_halt_ctrl;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       mwr;
    logic [7:0] mdin;
    logic [7:0] mdout;
    logic       shaltst_n;
    logic       busy_set, busy_clr, attn_ack;
    logic       shalt_n, subirq_n, mshgnt;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: requested halt level plus whether the sub CPU has
    // settled into that level, and the raw acknowledge sample history.
    bit m_req, m_settled, m_timeout, m_cancel, m_busy;
    int m_wait;
    bit samp[$];

    fm7_sub_halt_ctrl #(.TIMEOUT_CYC(TO)) dut (
        .SCPUCLK   (clk),
        .RESET     (rst),
        .MWR_FD05  (mwr),
        .MDIN      (mdin),
        .MDOUT     (mdout),
        .SHALTSTn  (shaltst_n),
        .SBUSY_SET (busy_set),
        .SBUSY_CLR (busy_clr),
        .SATTN_ACK (attn_ack),
        .SHALTn    (shalt_n),
        .SUBIRQn   (subirq_n),
        .MSHGNT    (mshgnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit s2;
        if (rst) begin
            m_req = 0; m_settled = 1; m_wait = 0; m_timeout = 0;
            m_cancel = 0; m_busy = 1;
            samp = '{1'b1, 1'b1};
            return;
        end
        s2 = samp.pop_front();
        samp.push_back(shaltst_n);
        if (m_req && !m_settled) begin
            m_wait++;
            if (m_wait == TO) m_timeout = 1;
        end
        if (mwr && (mdin[7] != m_req)) begin
            m_req = mdin[7];
            m_settled = 0;
            if (m_req) m_wait = 0;
        end else if (!m_settled && (s2 == !m_req)) begin
            m_settled = 1;
        end
        if (mwr || (m_req && m_settled)) m_timeout = 0;
        if (mwr && mdin[6]) m_cancel = 1;
        else if (attn_ack)  m_cancel = 0;
        if (busy_set)      m_busy = 1;
        else if (busy_clr) m_busy = 0;
        if (mwr)
            $display("t=%0t FD05 <= %02h  req=%0d granted=%0d cancel=%0d", $time, mdin,
                     m_req, m_req && m_settled, m_cancel);
    endtask

    task automatic step();
        logic [7:0] exp_out;
        @(posedge clk);
        model_edge();
        #1;
        exp_out = {m_busy, m_cancel, m_timeout, 4'b1111, m_req && m_settled};
        chk("mdout",   mdout,          exp_out);
        chk("shaltn",  {7'd0, shalt_n},  {7'd0, !m_req});
        chk("subirqn", {7'd0, subirq_n}, {7'd0, !m_cancel});
        chk("mshgnt",  {7'd0, mshgnt},   {7'd0, m_req && m_settled});
    endtask

    task automatic wr(input logic [7:0] d);
        mwr = 1'b1; mdin = d;
        step();
        mwr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; mwr = 1'b0; mdin = 8'h00; shaltst_n = 1'b1;
        busy_set = 1'b0; busy_clr = 1'b0; attn_ack = 1'b0;
        #1;
        step(); step();
        rst = 1'b0;
        step();
        chk("rst_mdout", mdout, 8'h9E);
        chk("rst_shaltn", {7'd0, shalt_n}, 8'h01);
        chk("rst_subirqn", {7'd0, subirq_n}, 8'h01);
        chk("rst_mshgnt", {7'd0, mshgnt}, 8'h00);

        // Halt request and 3-edge acknowledge latency
        wr(8'h80);
        chk("hreq_shaltn", {7'd0, shalt_n}, 8'h00);
        repeat (4) step();
        shaltst_n = 1'b0;
        step(); step();
        chk("ack_early_gnt", {7'd0, mshgnt}, 8'h00);
        step();
        chk("ack_gnt", {7'd0, mshgnt}, 8'h01);
        chk("ack_halted", {7'd0, mdout[0]}, 8'h01);

        // Release drops grant on the write edge
        wr(8'h00);
        chk("rel_gnt", {7'd0, mshgnt}, 8'h00);
        chk("rel_shaltn", {7'd0, shalt_n}, 8'h01);
        shaltst_n = 1'b1;
        repeat (6) step();

        // Timeout while the acknowledge never arrives
        wr(8'h80);
        repeat (TO - 1) step();
        chk("to_early", {7'd0, mdout[5]}, 8'h00);
        step();
        chk("to_set", {7'd0, mdout[5]}, 8'h01);
        chk("to_shaltn", {7'd0, shalt_n}, 8'h00);
        shaltst_n = 1'b0;
        repeat (3) step();
        chk("to_gnt", {7'd0, mshgnt}, 8'h01);
        chk("to_clr", {7'd0, mdout[5]}, 8'h00);
        wr(8'h00);
        shaltst_n = 1'b1;
        repeat (4) step();

        // Cancel IRQ: set beats a simultaneous ack
        wr(8'h40);
        chk("irq_set", {7'd0, subirq_n}, 8'h00);
        attn_ack = 1'b1;
        wr(8'h40);
        attn_ack = 1'b0;
        chk("irq_set_wins", {7'd0, subirq_n}, 8'h00);
        step();
        attn_ack = 1'b1;
        step();
        attn_ack = 1'b0;
        chk("irq_ack", {7'd0, subirq_n}, 8'h01);

        // Reset while halted with cancel pending and busy clear
        busy_clr = 1'b1;
        wr(8'hC0);
        busy_clr = 1'b0;
        shaltst_n = 1'b0;
        repeat (4) step();
        chk("pre_rst_mdout", mdout, 8'h5F);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_mdout", mdout, 8'h9E);
        chk("mid_rst_shaltn", {7'd0, shalt_n}, 8'h01);
        chk("mid_rst_gnt", {7'd0, mshgnt}, 8'h00);
        chk("mid_rst_subirqn", {7'd0, subirq_n}, 8'h01);
        shaltst_n = 1'b1;
        repeat (3) step();

        // Random traffic, including sub-cycle acknowledge glitches
        for (int i = 0; i < 4000; i++) begin
            rst      = ($urandom_range(0, 599) == 0);
            mwr      = ($urandom_range(0, 5) == 0);
            mdin     = 8'($urandom);
            busy_set = ($urandom_range(0, 9) == 0);
            busy_clr = ($urandom_range(0, 9) == 0);
            attn_ack = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 19) == 0) shaltst_n = ~shaltst_n;
            if ($urandom_range(0, 15) == 0) begin
                shaltst_n = ~shaltst_n;
                #1;
                shaltst_n = ~shaltst_n;
            end
            step();
        end
        rst = 1'b0; mwr = 1'b0; busy_set = 1'b0; busy_clr = 1'b0; attn_ack = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
